// File: rtl/clock_pkg.sv
// Shared constants, select codes, alarm state type and display helper
// for the alarm clock slice.
package clock_pkg;
  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HOUR_W   = 5;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  localparam logic [2:0] SEL_RUN      = 3'd0;
  localparam logic [2:0] SEL_SEC      = 3'd1;
  localparam logic [2:0] SEL_MIN      = 3'd2;
  localparam logic [2:0] SEL_HOUR     = 3'd3;
  localparam logic [2:0] SEL_ALM_MIN  = 3'd4;
  localparam logic [2:0] SEL_ALM_HOUR = 3'd5;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} alarm_state_t;

  // 24h hour to 12h dial value: 0 and 12 both show as 12.
  function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] hour);
    logic [HOUR_W-1:0] h;
    h = (hour >= 5'd12) ? hour - 5'd12 : hour;
    return (h == '0) ? 5'd12 : h;
  endfunction
endpackage

// File: rtl/alarm_clock_if.sv
// Control and display bundle between the alarm clock and its user
// (buttons/selector on one side, display/buzzer drivers on the other).
interface alarm_clock_if;
  import clock_pkg::*;

  logic [2:0]        select;
  logic              increment;
  logic              decrement;
  logic              mode_12h;
  logic              alarm_en;
  logic              snooze;
  logic [SEC_W-1:0]  sec_out;
  logic [MIN_W-1:0]  min_out;
  logic [HOUR_W-1:0] hour_out;
  logic [HOUR_W-1:0] disp_hour;
  logic              pm;
  logic [MIN_W-1:0]  alarm_min_out;
  logic [HOUR_W-1:0] alarm_hour_out;
  logic              ringing;
  logic              tick;

  modport master (
    output select, increment, decrement, mode_12h, alarm_en, snooze,
    input  sec_out, min_out, hour_out, disp_hour, pm,
           alarm_min_out, alarm_hour_out, ringing, tick
  );

  modport slave (
    input  select, increment, decrement, mode_12h, alarm_en, snooze,
    output sec_out, min_out, hour_out, disp_hour, pm,
           alarm_min_out, alarm_hour_out, ringing, tick
  );
endinterface

// File: rtl/mod_counter.sv
// Wrap-around up/down counter; next_value and carry are combinational so
// a chain of counters can all advance on the same edge.
module mod_counter #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value,
  output logic             carry
);
  always_comb begin
    next_value = value;
    carry      = 1'b0;
    if (load) begin
      next_value = load_value;
    end else if (inc && !dec) begin
      if (value == WIDTH'(MODULUS - 1)) begin
        next_value = '0;
        carry      = 1'b1;
      end else begin
        next_value = value + WIDTH'(1);
      end
    end else if (dec && !inc) begin
      next_value = (value == '0) ? WIDTH'(MODULUS - 1) : value - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) value <= '0;
    else        value <= next_value;
  end
endmodule

// File: rtl/alarm_clock.sv
// Time-of-day clock with button setting, 12/24h display, and an alarm
// with ring timeout and snooze.
module alarm_clock
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int SNOOZE_MIN    = 5,
  parameter int RING_SEC      = 60
) (
  input logic          clk,
  input logic          reset,
  alarm_clock_if.slave bus
);
  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [PRE_W-1:0]  prescale_reg;
  logic              tick_reg, inc_prev_reg, dec_prev_reg, snz_prev_reg;
  logic              set_mode, run_tick, inc_step, dec_step, snz_edge;
  logic              sel_sec, sel_min, sel_hour, sel_amin, sel_ahour;
  logic              alarm_edit, trigger;
  logic [SEC_W-1:0]  sec_val, sec_next;
  logic [MIN_W-1:0]  min_val, min_next, amin_val, amin_next;
  logic [HOUR_W-1:0] hour_val, hour_next, ahour_val, ahour_next;
  logic              sec_carry, min_carry, hour_carry, amin_carry, ahour_carry;
  logic [HOUR_W-1:0] disp_reg;
  logic              pm_reg, ringing_reg;
  alarm_state_t      state_reg;
  logic [7:0]        ring_cnt_reg;
  logic [MIN_W-1:0]  snz_min_reg, snz_min_calc;
  logic [HOUR_W-1:0] snz_hour_reg, snz_hour_calc;
  logic [6:0]        snz_sum;
  logic              unused_bits;

  assign set_mode = (bus.select != SEL_RUN) && (bus.select <= SEL_HOUR);
  assign run_tick = !set_mode && (prescale_reg == PRE_W'(TICKS_PER_SEC - 1));

  // Simultaneous inc and dec edges cancel out.
  assign inc_step = bus.increment && !inc_prev_reg && !(bus.decrement && !dec_prev_reg);
  assign dec_step = bus.decrement && !dec_prev_reg && !(bus.increment && !inc_prev_reg);
  assign snz_edge = bus.snooze && !snz_prev_reg;

  assign sel_sec    = (bus.select == SEL_SEC);
  assign sel_min    = (bus.select == SEL_MIN);
  assign sel_hour   = (bus.select == SEL_HOUR);
  assign sel_amin   = (bus.select == SEL_ALM_MIN);
  assign sel_ahour  = (bus.select == SEL_ALM_HOUR);
  assign alarm_edit = (sel_amin || sel_ahour) && (inc_step || dec_step);

  always_ff @(posedge clk) begin
    if (!reset) begin
      prescale_reg <= '0;
      tick_reg     <= 1'b0;
      inc_prev_reg <= 1'b0;
      dec_prev_reg <= 1'b0;
      snz_prev_reg <= 1'b0;
    end else begin
      prescale_reg <= (set_mode || run_tick) ? '0 : prescale_reg + PRE_W'(1);
      tick_reg     <= run_tick;
      inc_prev_reg <= bus.increment;
      dec_prev_reg <= bus.decrement;
      snz_prev_reg <= bus.snooze;
    end
  end

  mod_counter #(.MODULUS(MIN_MOD), .WIDTH(SEC_W)) u_sec (
    .clk(clk), .reset(reset),
    .inc(run_tick || (sel_sec && inc_step)), .dec(sel_sec && dec_step),
    .load(1'b0), .load_value('0),
    .value(sec_val), .next_value(sec_next), .carry(sec_carry));

  mod_counter #(.MODULUS(MIN_MOD), .WIDTH(MIN_W)) u_min (
    .clk(clk), .reset(reset),
    .inc((run_tick && sec_carry) || (sel_min && inc_step)), .dec(sel_min && dec_step),
    .load(1'b0), .load_value('0),
    .value(min_val), .next_value(min_next), .carry(min_carry));

  mod_counter #(.MODULUS(HOUR_MOD), .WIDTH(HOUR_W)) u_hour (
    .clk(clk), .reset(reset),
    .inc((run_tick && min_carry) || (sel_hour && inc_step)), .dec(sel_hour && dec_step),
    .load(1'b0), .load_value('0),
    .value(hour_val), .next_value(hour_next), .carry(hour_carry));

  mod_counter #(.MODULUS(MIN_MOD), .WIDTH(MIN_W)) u_alarm_min (
    .clk(clk), .reset(reset),
    .inc(sel_amin && inc_step), .dec(sel_amin && dec_step),
    .load(1'b0), .load_value('0),
    .value(amin_val), .next_value(amin_next), .carry(amin_carry));

  mod_counter #(.MODULUS(HOUR_MOD), .WIDTH(HOUR_W)) u_alarm_hour (
    .clk(clk), .reset(reset),
    .inc(sel_ahour && inc_step), .dec(sel_ahour && dec_step),
    .load(1'b0), .load_value('0),
    .value(ahour_val), .next_value(ahour_next), .carry(ahour_carry));

  assign unused_bits = ^{hour_carry, amin_carry, ahour_carry, amin_next, ahour_next};

  // Only a running tick that rolls the seconds over can hit hh:mm:00.
  assign trigger = run_tick && sec_carry && bus.alarm_en &&
                   (((min_next == amin_val) && (hour_next == ahour_val)) ||
                    ((state_reg == SNOOZED) && (min_next == snz_min_reg) &&
                     (hour_next == snz_hour_reg)));

  always_comb begin
    snz_sum       = {1'b0, min_val} + 7'(SNOOZE_MIN);
    snz_min_calc  = snz_sum[MIN_W-1:0];
    snz_hour_calc = hour_val;
    if (snz_sum >= 7'(MIN_MOD)) begin
      snz_min_calc  = MIN_W'(snz_sum - 7'(MIN_MOD));
      snz_hour_calc = (hour_val == HOUR_W'(HOUR_MOD - 1)) ? '0 : hour_val + HOUR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      ringing_reg  <= 1'b0;
      ring_cnt_reg <= '0;
      snz_min_reg  <= '0;
      snz_hour_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (trigger) begin
          state_reg    <= RINGING;
          ringing_reg  <= 1'b1;
          ring_cnt_reg <= '0;
        end
        RINGING: begin
          if (!bus.alarm_en) begin
            state_reg   <= IDLE;
            ringing_reg <= 1'b0;
          end else if (trigger) begin
            ring_cnt_reg <= '0;
          end else if (snz_edge) begin
            state_reg    <= SNOOZED;
            ringing_reg  <= 1'b0;
            snz_min_reg  <= snz_min_calc;
            snz_hour_reg <= snz_hour_calc;
          end else if (run_tick) begin
            if (ring_cnt_reg == 8'(RING_SEC - 1)) begin
              state_reg   <= IDLE;
              ringing_reg <= 1'b0;
            end else begin
              ring_cnt_reg <= ring_cnt_reg + 8'd1;
            end
          end
        end
        SNOOZED: begin
          if (!bus.alarm_en || alarm_edit) begin
            state_reg <= IDLE;
          end else if (trigger) begin
            state_reg    <= RINGING;
            ringing_reg  <= 1'b1;
            ring_cnt_reg <= '0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          ringing_reg <= 1'b0;
        end
      endcase
    end
  end

  // Display is encoded from the upcoming hour so it tracks hour_out exactly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      disp_reg <= '0;
      pm_reg   <= 1'b0;
    end else begin
      disp_reg <= bus.mode_12h ? to_12h(hour_next) : hour_next;
      pm_reg   <= bus.mode_12h && (hour_next >= 5'd12);
    end
  end

  assign bus.sec_out        = sec_val;
  assign bus.min_out        = min_val;
  assign bus.hour_out       = hour_val;
  assign bus.disp_hour      = disp_reg;
  assign bus.pm             = pm_reg;
  assign bus.alarm_min_out  = amin_val;
  assign bus.alarm_hour_out = ahour_val;
  assign bus.ringing        = ringing_reg;
  assign bus.tick           = tick_reg;
endmodule

// File: tb/tb_alarm_clock.sv
// Directed bench for alarm_clock: a table of set-mode vectors plus
// hand-written sequences for running time, alarm, snooze and reset.
module tb_alarm_clock;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  alarm_clock_if bus();

  alarm_clock #(.TICKS_PER_SEC(2), .SNOOZE_MIN(5), .RING_SEC(4)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic       inc;
    logic       dec;
    logic       m12;
    int         sec;
    int         min;
    int         hour;
    int         disp;
    int         pm;
  } vec_t;

  vec_t vecs[17];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic press(input logic [2:0] sel, input bit up);
    bus.select = sel;
    if (up) bus.increment = 1'b1;
    else    bus.decrement = 1'b1;
    step(1);
    bus.increment = 1'b0;
    bus.decrement = 1'b0;
    step(1);
  endtask

  task automatic wait_tick(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (bus.tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ring(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (bus.ringing) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int ticks;
    bit ok;

    vecs = '{
      '{3'd1, 1'b1, 1'b0, 1'b0,  1, 2,  0,  0, 0},
      '{3'd1, 1'b1, 1'b0, 1'b0,  1, 2,  0,  0, 0},
      '{3'd1, 1'b0, 1'b0, 1'b0,  1, 2,  0,  0, 0},
      '{3'd1, 1'b0, 1'b1, 1'b0,  0, 2,  0,  0, 0},
      '{3'd1, 1'b0, 1'b0, 1'b0,  0, 2,  0,  0, 0},
      '{3'd1, 1'b0, 1'b1, 1'b0, 59, 2,  0,  0, 0},
      '{3'd1, 1'b0, 1'b0, 1'b0, 59, 2,  0,  0, 0},
      '{3'd1, 1'b1, 1'b1, 1'b0, 59, 2,  0,  0, 0},
      '{3'd1, 1'b0, 1'b0, 1'b0, 59, 2,  0,  0, 0},
      '{3'd1, 1'b1, 1'b0, 1'b0,  0, 2,  0,  0, 0},
      '{3'd1, 1'b0, 1'b0, 1'b0,  0, 2,  0,  0, 0},
      '{3'd3, 1'b0, 1'b1, 1'b0,  0, 2, 23, 23, 0},
      '{3'd3, 1'b0, 1'b0, 1'b1,  0, 2, 23, 11, 1},
      '{3'd3, 1'b1, 1'b0, 1'b1,  0, 2,  0, 12, 0},
      '{3'd3, 1'b0, 1'b0, 1'b0,  0, 2,  0,  0, 0},
      '{3'd2, 1'b0, 1'b1, 1'b0,  0, 1,  0,  0, 0},
      '{3'd2, 1'b0, 1'b0, 1'b0,  0, 1,  0,  0, 0}
    };

    reset = 1'b0;
    bus.select = 3'd0; bus.increment = 1'b0; bus.decrement = 1'b0;
    bus.mode_12h = 1'b0; bus.alarm_en = 1'b0; bus.snooze = 1'b0;
    step(1);
    chk("rst_sec", bus.sec_out, 0);
    chk("rst_hour", bus.hour_out, 0);
    chk("rst_tick", bus.tick, 0);
    reset = 1'b1;

    ticks = 0;
    for (int i = 0; i < 240; i++) begin
      step(1);
      if (bus.tick) ticks++;
    end
    chk("run_ticks", ticks, 120);
    chk("run_sec", bus.sec_out, 0);
    chk("run_min", bus.min_out, 2);
    chk("run_hour", bus.hour_out, 0);
    chk("run_ringing", bus.ringing, 0);

    for (int i = 0; i < 17; i++) begin
      bus.select    = vecs[i].sel;
      bus.increment = vecs[i].inc;
      bus.decrement = vecs[i].dec;
      bus.mode_12h  = vecs[i].m12;
      step(1);
      chk($sformatf("v%0d_sec", i), bus.sec_out, vecs[i].sec);
      chk($sformatf("v%0d_min", i), bus.min_out, vecs[i].min);
      chk($sformatf("v%0d_hour", i), bus.hour_out, vecs[i].hour);
      chk($sformatf("v%0d_disp", i), bus.disp_hour, vecs[i].disp);
      chk($sformatf("v%0d_pm", i), bus.pm, vecs[i].pm);
    end

    // 23:59:59 rolls to 00:00:00 with the alarm disarmed
    press(3'd1, 1'b0);
    press(3'd2, 1'b0);
    press(3'd2, 1'b0);
    press(3'd3, 1'b0);
    chk("max_sec", bus.sec_out, 59);
    chk("max_min", bus.min_out, 59);
    chk("max_hour", bus.hour_out, 23);
    bus.select = 3'd0;
    wait_tick(6, ok);
    chk("roll_tick_seen", ok, 1);
    chk("roll_sec", bus.sec_out, 0);
    chk("roll_min", bus.min_out, 0);
    chk("roll_hour", bus.hour_out, 0);
    chk("roll_ringing", bus.ringing, 0);

    // alarm 00:01, time 00:00:59, then snooze to 00:06
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    press(3'd4, 1'b1);
    chk("alm_min_set", bus.alarm_min_out, 1);
    chk("alm_hour_set", bus.alarm_hour_out, 0);
    press(3'd1, 1'b0);
    press(3'd1, 1'b0);
    chk("pre_alm_sec", bus.sec_out, 59);
    chk("pre_alm_min", bus.min_out, 0);
    bus.alarm_en = 1'b1;
    bus.select = 3'd0;
    wait_ring(10, ok);
    chk("ring1_rise", ok, 1);
    chk("ring1_sec", bus.sec_out, 0);
    chk("ring1_min", bus.min_out, 1);
    bus.snooze = 1'b1;
    step(1);
    chk("snooze_clear", bus.ringing, 0);
    bus.snooze = 1'b0;
    wait_ring(800, ok);
    chk("ring2_rise", ok, 1);
    chk("ring2_sec", bus.sec_out, 0);
    chk("ring2_min", bus.min_out, 6);
    chk("ring2_hour", bus.hour_out, 0);

    // ring timeout after four ticks
    for (int k = 1; k <= 4; k++) begin
      wait_tick(6, ok);
      chk($sformatf("to_tick%0d_seen", k), ok, 1);
      chk($sformatf("to_tick%0d_ringing", k), bus.ringing, (k < 4) ? 1 : 0);
    end
    chk("to_sec", bus.sec_out, 4);

    // disarm while ringing
    for (int k = 0; k < 6; k++) press(3'd4, 1'b1);
    chk("alm_min7", bus.alarm_min_out, 7);
    bus.select = 3'd0;
    wait_ring(400, ok);
    chk("ring3_rise", ok, 1);
    chk("ring3_min", bus.min_out, 7);
    chk("ring3_sec", bus.sec_out, 0);
    bus.alarm_en = 1'b0;
    step(1);
    chk("disarm_clear", bus.ringing, 0);

    // reset in the middle of a ring
    bus.alarm_en = 1'b1;
    press(3'd4, 1'b1);
    bus.select = 3'd0;
    bus.mode_12h = 1'b1;
    wait_ring(400, ok);
    chk("ring4_rise", ok, 1);
    chk("ring4_min", bus.min_out, 8);
    reset = 1'b0;
    step(1);
    chk("mid_rst_ringing", bus.ringing, 0);
    chk("mid_rst_sec", bus.sec_out, 0);
    chk("mid_rst_min", bus.min_out, 0);
    chk("mid_rst_hour", bus.hour_out, 0);
    chk("mid_rst_disp", bus.disp_hour, 0);
    chk("mid_rst_pm", bus.pm, 0);
    chk("mid_rst_tick", bus.tick, 0);
    chk("mid_rst_alm_min", bus.alarm_min_out, 0);
    chk("mid_rst_alm_hour", bus.alarm_hour_out, 0);
    reset = 1'b1;
    step(1);
    chk("post_rst_disp12", bus.disp_hour, 12);
    chk("post_rst_ringing", bus.ringing, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
